set_assoc_cache_ctrl: RTL

Parametrised N-way set-associative read cache between the memory stage and the SRAM controller. Lines are 64 bits (two words). Write policy is write-through, no-allocate. Replacement is tree pseudo-LRU. The block replaces the fixed 2-way cache with a multi-cycle miss FSM, a flush command and exported hit/read statistics.

---
 rtl/set_assoc_cache_ctrl_if.sv | 33 +++
 rtl/set_assoc_cache_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// set_assoc_cache_ctrl_if : requester and SRAM-side signal bundle of the cache.
// Rev 1.0
// ---------------------------------------------------------------------------
interface set_assoc_cache_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        flush;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_adr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [31:0] hit_cnt;
  logic [31:0] read_cnt;

  modport slave (
    input  rd_en, wr_en, adr, wdata, flush, sram_rdata, sram_ready,
    output rdata, ready, sram_rd_en, sram_wr_en, sram_adr, sram_wdata, hit_cnt, read_cnt
  );

  modport master (
    output rd_en, wr_en, adr, wdata, flush, sram_rdata, sram_ready,
    input  rdata, ready, sram_rd_en, sram_wr_en, sram_adr, sram_wdata, hit_cnt, read_cnt
  );
endinterface
`default_nettype wire

// File: rtl/set_assoc_cache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// set_assoc_cache_ctrl : N-way set-associative write-through read cache with
// tree pseudo-LRU replacement, flush and hit/read statistics.  Rev 1.0
// ---------------------------------------------------------------------------
module set_assoc_cache_ctrl #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  set_assoc_cache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WTHRU = 2'd2
  } state_e;

  state_e                      state_q;
  logic                        flush_pend_q;
  logic [SETS-1:0][WAYS-1:0]   valid_q;
  logic [SETS-1:0][WAYS-2:0]   plru_q;
  logic [31:0]                 hit_cnt_q;
  logic [31:0]                 read_cnt_q;
  logic [TAG_W-1:0]            tag_q  [SETS][WAYS];
  logic [63:0]                 data_q [SETS][WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             rd_hit, fill_done, wr_done, flush_now;
  logic             unused_adr;

  assign idx        = bus.adr[3 +: IDX_W];
  assign tag        = bus.adr[3 + IDX_W +: TAG_W];
  assign word_sel   = bus.adr[2];
  assign unused_adr = ^{bus.adr[1:0], bus.adr >> (3 + IDX_W + TAG_W)};

  // Tree walk: node n has children 2n+1 (left, lower ways) and 2n+2 (right).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int n;
    n = 0;
    plru_victim = '0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_victim[WAY_W-1-l] = bits[n];
      n = 2 * n + 1 + int'(bits[n]);
    end
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    int n;
    n = 0;
    plru_touch = bits;
    for (int l = 0; l < WAY_W; l++) begin
      plru_touch[n] = ~way[WAY_W-1-l];
      n = 2 * n + 1 + int'(way[WAY_W-1-l]);
    end
  endfunction

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    hit = |hit_vec;
  end

  always_comb begin
    victim = plru_victim(plru_q[idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = WAY_W'(w);
    end
  end

  assign rd_hit    = (state_q == IDLE) && bus.rd_en && !bus.wr_en && hit;
  assign fill_done = (state_q == FILL) && bus.sram_ready;
  assign wr_done   = (state_q == WTHRU) && bus.sram_ready;
  assign flush_now = (state_q == IDLE) && (bus.flush || flush_pend_q);

  always_comb begin
    bus.ready = rd_hit || fill_done || wr_done;
    bus.rdata = '0;
    if (rd_hit)
      bus.rdata = word_sel ? data_q[idx][hit_way][63:32] : data_q[idx][hit_way][31:0];
    else if (fill_done)
      bus.rdata = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
  end

  assign bus.sram_rd_en = (state_q == FILL);
  assign bus.sram_wr_en = (state_q == WTHRU);
  assign bus.sram_adr   = bus.adr;
  assign bus.sram_wdata = bus.wdata;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.read_cnt   = read_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      plru_q       <= '0;
      hit_cnt_q    <= '0;
      read_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_en)             state_q <= WTHRU;
          else if (bus.rd_en && !hit) state_q <= FILL;
        end
        FILL:    if (bus.sram_ready) state_q <= IDLE;
        WTHRU:   if (bus.sram_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (rd_hit) begin
        plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
        hit_cnt_q   <= hit_cnt_q + 32'd1;
        read_cnt_q  <= read_cnt_q + 32'd1;
      end
      if (fill_done) begin
        valid_q[idx][victim] <= 1'b1;
        plru_q[idx]          <= plru_touch(plru_q[idx], victim);
        read_cnt_q           <= read_cnt_q + 32'd1;
      end
      if (wr_done && hit)
        plru_q[idx] <= plru_touch(plru_q[idx], hit_way);

      if ((state_q != IDLE) && bus.flush)
        flush_pend_q <= 1'b1;
      // Flush lands last so a read in the same IDLE cycle still used the old contents.
      if (flush_now) begin
        valid_q      <= '0;
        plru_q       <= '0;
        hit_cnt_q    <= '0;
        read_cnt_q   <= '0;
        flush_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= bus.sram_rdata;
    end else if (wr_done && hit) begin
      if (word_sel) data_q[idx][hit_way][63:32] <= bus.wdata;
      else          data_q[idx][hit_way][31:0]  <= bus.wdata;
    end
  end
endmodule
`default_nettype wire
